ad9910_serial_readback: RTL and testbench

Serial register reader for one AD9910 DDS on the shared 3-wire serial bus (CS, SCLK, bidirectional SDIO). It issues a read instruction for a requested register address, releases SDIO, shifts in 16, 32 or 64 data bits MSB-first, and presents the word with a one-cycle valid strobe. It sits beside the per-chip serial writer on the same iAddr-selected bus and gives the host readback and verification of programmed CFR, FTW and profile contents.

---
 rtl/ad9910_pkg.sv | 55 +++++
 rtl/ad9910_serial_readback_if.sv | 22 ++
 rtl/ad9910_serial_readback_sclk_gen.sv | 38 +++
 rtl/ad9910_serial_readback.sv | 127 ++++++++++++
 tb/tb_ad9910_serial_readback.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ad9910_pkg.sv
// Shared AD9910 serial-bus definitions: register map, readback widths, read-instruction format.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ad9910_pkg;

  // Register addresses used by both the serial writer and the readback engine
  localparam logic [4:0] REG_CFR1     = 5'h00;
  localparam logic [4:0] REG_CFR2     = 5'h01;
  localparam logic [4:0] REG_CFR3     = 5'h02;
  localparam logic [4:0] REG_FTW      = 5'h07;
  localparam logic [4:0] REG_POW      = 5'h08;
  localparam logic [4:0] REG_ASF      = 5'h09;
  localparam logic [4:0] REG_PROFILE0 = 5'h0E;
  localparam logic [4:0] REG_PROFILE1 = 5'h0F;
  localparam logic [4:0] REG_PROFILE2 = 5'h10;
  localparam logic [4:0] REG_PROFILE3 = 5'h11;
  localparam logic [4:0] REG_PROFILE4 = 5'h12;
  localparam logic [4:0] REG_PROFILE5 = 5'h13;
  localparam logic [4:0] REG_PROFILE6 = 5'h14;
  localparam logic [4:0] REG_PROFILE7 = 5'h15;

  // Instruction byte: bit 7 selects read, bits 4:0 carry the register address
  localparam int INSTR_RD_BIT = 7;
  localparam int INSTR_BITS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INSTR,
    ST_DATA,
    ST_DONE
  } rdState_t;

  // Readback width in bits for a register address; 0 means not readable
  function automatic logic [6:0] regWidth(input logic [4:0] addr);
    logic [6:0] w;
    case (addr)
      5'h00, 5'h01, 5'h02, 5'h03, 5'h04,
      5'h07, 5'h09, 5'h0A, 5'h0D:          w = 7'd32;
      5'h08:                               w = 7'd16;
      5'h0B, 5'h0C, 5'h0E, 5'h0F, 5'h10,
      5'h11, 5'h12, 5'h13, 5'h14, 5'h15:   w = 7'd64;
      default:                             w = 7'd0;
    endcase
    return w;
  endfunction

  // Read instruction byte sent MSB-first
  function automatic logic [7:0] readInstr(input logic [4:0] addr);
    logic [7:0] b;
    b = {3'b000, addr};
    b[INSTR_RD_BIT] = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/ad9910_serial_readback_if.sv
// Host-side request/response bundle of the AD9910 readback engine.
// Latency: n/a (wiring only).
// Backpressure: host may request only while oReady is high; responses are strobes, not held.
interface ad9910_serial_readback_if;
  logic [3:0]  iAddr;
  logic [4:0]  iRegAddr;
  logic        iTrig;
  logic        oReady;
  logic [63:0] oData;
  logic        oValid;
  logic        oErr;

  modport master (
    output iAddr, iRegAddr, iTrig,
    input  oReady, oData, oValid, oErr
  );

  modport slave (
    input  iAddr, iRegAddr, iTrig,
    output oReady, oData, oValid, oErr
  );
endinterface

// File: rtl/ad9910_serial_readback_sclk_gen.sv
// SCLK generator: P_HALF cycles low then P_HALF high per bit while iRun, with rise/end-of-high strobes.
// Latency: SCLK level registered; oRise flags the cycle before the level goes high, oEndHigh the last high cycle.
// Backpressure: none; dropping iRun parks SCLK low and restarts the bit at its low phase.
module sclk_gen #(
  parameter int P_HALF = 2
) (
  input  logic iClk,
  input  logic iResetN,
  input  logic iRun,
  output logic oSclk,
  output logic oRise,
  output logic oEndHigh
);

  localparam int CW = $clog2(2 * P_HALF);
  localparam logic [CW-1:0] HALF_M1 = CW'(P_HALF - 1);
  localparam logic [CW-1:0] LAST    = CW'(2 * P_HALF - 1);

  logic [CW-1:0] cnt;

  assign oRise    = iRun && (cnt == HALF_M1);
  assign oEndHigh = iRun && (cnt == LAST);

  // Half-period counter; level flips high after the low half and back low at wrap
  always_ff @(posedge iClk) begin
    if (!iResetN || !iRun) begin
      cnt   <= '0;
      oSclk <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      oSclk <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == HALF_M1) oSclk <= 1'b1;
    end
  end

endmodule

// File: rtl/ad9910_serial_readback.sv
// AD9910 register reader: sends read instruction, releases SDIO, shifts in 16/32/64 bits MSB-first.
// Latency: oValid 1 + 2*P_HALF*(8+N) cycles after accept; oErr 1 cycle after accept for unreadable addresses.
// Backpressure: oReady low while a read is in flight; iTrig during that time is dropped, not queued.
module ad9910_serial_readback
  import ad9910_pkg::*;
#(
  parameter logic [3:0] P_ADDR = 4'd0,
  parameter int         P_HALF = 2
) (
  input  logic                       iClk,
  input  logic                       iResetN,
  ad9910_serial_readback_if.slave    bus,
  inout  wire                        ioSCLK,
  inout  wire                        ioSDIO,
  output logic                       oCS
);

  rdState_t    state;
  logic [7:0]  instrSh;
  logic [6:0]  bitCnt;     // SCLK rises seen in this transaction (instruction + data)
  logic [6:0]  width;
  logic [63:0] shiftReg;
  logic        sdioOut;
  logic        sdioOe;
  logic        sclkOe;
  logic        sclkLvl;
  logic        sclkRise;
  logic        sclkEndHigh;
  logic        genRun;
  logic        accept;
  logic [6:0]  reqWidth;
  logic [7:0]  instrWord;

  assign reqWidth  = regWidth(bus.iRegAddr);
  assign instrWord = readInstr(bus.iRegAddr);
  assign accept    = bus.iTrig && bus.oReady && (bus.iAddr == P_ADDR);
  assign genRun    = (state == ST_INSTR) || (state == ST_DATA);

  // A transaction can only start while selected, so being busy implies ownership;
  // once busy the bus stays ours regardless of iAddr until back in IDLE.
  assign sclkOe = (state != ST_IDLE) || (bus.iAddr == P_ADDR);
  assign ioSCLK = sclkOe ? sclkLvl : 1'bz;
  assign ioSDIO = sdioOe ? sdioOut : 1'bz;

  sclk_gen #(.P_HALF(P_HALF)) uSclkGen (
    .iClk     (iClk),
    .iResetN  (iResetN),
    .iRun     (genRun),
    .oSclk    (sclkLvl),
    .oRise    (sclkRise),
    .oEndHigh (sclkEndHigh)
  );

  // Read sequencer: instruction byte out, data word in, one-cycle result strobe
  always_ff @(posedge iClk) begin
    if (!iResetN) begin
      state      <= ST_IDLE;
      bus.oReady <= 1'b1;
      bus.oValid <= 1'b0;
      bus.oErr   <= 1'b0;
      bus.oData  <= '0;
      oCS        <= 1'b1;
      sdioOe     <= 1'b0;
      sdioOut    <= 1'b0;
      instrSh    <= '0;
      bitCnt     <= '0;
      width      <= '0;
      shiftReg   <= '0;
    end else begin
      bus.oValid <= 1'b0;
      bus.oErr   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (reqWidth == 7'd0) begin
              bus.oErr <= 1'b1;
            end else begin
              state      <= ST_INSTR;
              bus.oReady <= 1'b0;
              oCS        <= 1'b0;
              sdioOe     <= 1'b1;
              sdioOut    <= instrWord[INSTR_BITS-1];
              instrSh    <= instrWord;
              width      <= reqWidth;
              bitCnt     <= '0;
              shiftReg   <= '0;
            end
          end
        end
        ST_INSTR: begin
          if (sclkRise) bitCnt <= bitCnt + 7'd1;
          if (sclkEndHigh) begin
            if (bitCnt == 7'(INSTR_BITS)) begin
              // Hand SDIO to the chip as SCLK drops after the 8th high phase
              sdioOe  <= 1'b0;
              sdioOut <= 1'b0;
              state   <= ST_DATA;
            end else begin
              // Next instruction bit appears at the start of the low phase
              sdioOut <= instrSh[INSTR_BITS-2];
              instrSh <= {instrSh[INSTR_BITS-2:0], 1'b0};
            end
          end
        end
        ST_DATA: begin
          if (sclkRise) bitCnt <= bitCnt + 7'd1;
          if (sclkEndHigh) begin
            // Zeroed at accept, so short words end up right-justified with zero upper bits
            shiftReg <= {shiftReg[62:0], ioSDIO};
            if (bitCnt == 7'(INSTR_BITS) + width) begin
              state      <= ST_DONE;
              oCS        <= 1'b1;
              bus.oValid <= 1'b1;
              bus.oData  <= {shiftReg[62:0], ioSDIO};
            end
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          bus.oReady <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9910_serial_readback.sv
// Bench for ad9910_serial_readback: responder model on the serial pins plus queued scoreboard.
// Latency: expected strobe cycle derived from the bit count of each read.
// Backpressure: stimulus waits for oReady before each request.
module tb_ad9910_serial_readback;

  localparam int P_HALF = 2;

  typedef struct {
    bit          isErr;
    logic [63:0] data;
    int          due;
  } exp_t;

  logic iClk = 1'b0;
  logic iResetN = 1'b0;
  wire  ioSCLK;
  wire  ioSDIO;
  logic oCS;

  ad9910_serial_readback_if bus ();

  ad9910_serial_readback #(.P_ADDR(4'd0), .P_HALF(P_HALF)) dut (
    .iClk    (iClk),
    .iResetN (iResetN),
    .bus     (bus),
    .ioSCLK  (ioSCLK),
    .ioSDIO  (ioSDIO),
    .oCS     (oCS)
  );

  always #5 iClk = ~iClk;

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;
  exp_t sbq[$];
  exp_t monIt;
  logic [63:0] lastData = '0;
  int zViol = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    nTests++;
    if (!ok) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Reference rules straight from the register map
  function automatic int modelWidth(input int a);
    if (a <= 4 || a == 7 || a == 9 || a == 10 || a == 13) return 32;
    if (a == 8) return 16;
    if (a == 11 || a == 12 || (a >= 14 && a <= 21)) return 64;
    return 0;
  endfunction

  function automatic logic [63:0] modelMask(input int n);
    if (n >= 64) return '1;
    return (64'h1 << n) - 64'h1;
  endfunction

  // ---------------- Responder: behaves like the chip on SCLK/SDIO ----------------
  logic [63:0] respWord = '0;
  int          respN = 0;
  int          riseCnt = 0;
  int          fallCnt = 0;
  int          lastRises = 0;
  logic [7:0]  instrCap = '0;
  int          respIdx;
  logic        respBit;
  logic        respDrv;

  always @(posedge ioSCLK or posedge oCS) begin
    if (oCS) begin
      if (riseCnt != 0) lastRises = riseCnt;
      riseCnt = 0;
    end else begin
      if (riseCnt < 8) instrCap = {instrCap[6:0], ioSDIO};
      riseCnt = riseCnt + 1;
    end
  end

  always @(negedge ioSCLK or posedge oCS) begin
    if (oCS) fallCnt = 0;
    else     fallCnt = fallCnt + 1;
  end

  always_comb begin
    respIdx = respN - 1 - (fallCnt - 8);
    respBit = 1'b0;
    if (respIdx >= 0 && respIdx < 64) respBit = respWord[respIdx[5:0]];
  end

  assign respDrv = !oCS && (fallCnt >= 8) && (fallCnt < 8 + respN);
  assign ioSDIO  = respDrv ? respBit : 1'bz;

  // ---------------- Monitor: pops one expectation per result strobe ----------------
  always @(negedge iClk) begin
    if (iResetN && (bus.oValid || bus.oErr)) begin
      if (sbq.size() == 0) begin
        check(1'b0, "unexpected_strobe", {62'd0, bus.oErr, bus.oValid}, 64'd0);
      end else begin
        monIt = sbq.pop_front();
        check(bus.oErr == monIt.isErr && bus.oValid == !monIt.isErr, "strobe_kind",
              {62'd0, bus.oErr, bus.oValid}, monIt.isErr ? 64'd2 : 64'd1);
        check(cyc == monIt.due, "strobe_cycle", 64'(cyc), 64'(monIt.due));
        check(bus.oData == monIt.data, "odata", bus.oData, monIt.data);
      end
    end
    if (!oCS && fallCnt >= 8 && dut.sdioOe) zViol++;
  end

  // ---------------- Stimulus helpers ----------------
  task automatic startRead(input logic [4:0] a, input logic [63:0] w);
    int n;
    int k;
    exp_t it;
    k = 0;
    while (!bus.oReady && k < 2000) begin
      @(posedge iClk); #1;
      k++;
    end
    if (!bus.oReady) check(1'b0, "ready_timeout", 64'd0, 64'd1);
    n = modelWidth(int'(a));
    respWord = w;
    respN    = n;
    bus.iRegAddr = a;
    bus.iTrig    = 1'b1;
    it.isErr = (n == 0);
    it.data  = (n == 0) ? lastData : (w & modelMask(n));
    it.due   = (n == 0) ? cyc + 1 : cyc + 1 + 2 * P_HALF * (8 + n);
    if (n != 0) lastData = it.data;
    sbq.push_back(it);
    @(posedge iClk); #1;
    bus.iTrig = 1'b0;
  endtask

  task automatic waitDone();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 1000) begin
      @(posedge iClk);
      k++;
    end
    if (sbq.size() != 0) begin
      check(1'b0, "done_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    @(posedge iClk); #1;
  endtask

  task automatic readFull(input logic [4:0] a, input logic [63:0] w);
    int zBefore;
    zBefore = zViol;
    startRead(a, w);
    waitDone();
    if (modelWidth(int'(a)) != 0) begin
      check(instrCap == (8'h80 | {3'b000, a}), "instr_byte", 64'(instrCap), 64'(8'h80 | {3'b000, a}));
      check(lastRises == 8 + modelWidth(int'(a)), "sclk_rises", 64'(lastRises), 64'(8 + modelWidth(int'(a))));
      check(zViol == zBefore, "sdio_released", 64'(zViol - zBefore), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int k;
    int bad;
    bus.iAddr    = 4'd0;
    bus.iRegAddr = 5'd0;
    bus.iTrig    = 1'b0;

    repeat (3) @(posedge iClk);
    #1 iResetN = 1'b1;
    check(bus.oReady == 1'b1, "rst_ready", 64'(bus.oReady), 64'd1);
    check(oCS == 1'b1, "rst_cs", 64'(oCS), 64'd1);
    check(bus.oData == 64'd0, "rst_odata", bus.oData, 64'd0);
    check(bus.oValid == 1'b0 && bus.oErr == 1'b0, "rst_strobes", {62'd0, bus.oErr, bus.oValid}, 64'd0);
    check(dut.sdioOe == 1'b0 && ioSCLK == 1'b0, "rst_pins", {62'd0, dut.sdioOe, ioSCLK}, 64'd0);

    // Directed reads: FTW, PROFILE0, POW (upper stimulus bits must be dropped)
    readFull(5'h07, 64'hDEAD_BEEF_1234_5678);
    readFull(5'h0E, 64'h08B5_0000_4000_0000);
    readFull(5'h08, 64'h5555_AAAA_9999_ABCD);

    // Unreadable address: error strobe only, no bus activity
    @(posedge iClk); #1;
    startRead(5'h05, 64'hFFFF_FFFF_FFFF_FFFF);
    check(bus.oReady == 1'b1, "err_ready", 64'(bus.oReady), 64'd1);
    bad = 0;
    repeat (6) begin
      if (oCS != 1'b1 || ioSCLK != 1'b0) bad++;
      @(posedge iClk); #1;
    end
    check(bad == 0 && riseCnt == 0, "err_no_bus", 64'(bad + riseCnt), 64'd0);
    waitDone();

    // Reset in the middle of data bit 10
    startRead(5'h07, 64'h0000_0000_CAFE_F00D);
    k = 0;
    while (fallCnt < 18 && k < 2000) begin
      @(posedge iClk); #1;
      k++;
    end
    check(fallCnt >= 18, "reach_data_bit10", 64'(fallCnt), 64'd18);
    iResetN = 1'b0;
    @(posedge iClk); #1;
    iResetN = 1'b1;
    sbq.delete();
    lastData = '0;
    check(oCS == 1'b1 && bus.oReady == 1'b1, "abort_idle", {62'd0, oCS, bus.oReady}, 64'd3);
    check(bus.oData == 64'd0 && bus.oValid == 1'b0, "abort_odata", bus.oData, 64'd0);
    check(dut.sdioOe == 1'b0 && ioSCLK == 1'b0, "abort_pins", {62'd0, dut.sdioOe, ioSCLK}, 64'd0);
    repeat (250) @(posedge iClk);
    #1;
    readFull(5'h0B, 64'h0123_4567_89AB_CDEF);

    // Extra trigger while busy, then chip select moves away mid-transaction
    startRead(5'h0F, 64'hFEDC_BA98_7654_3210);
    repeat (20) @(posedge iClk);
    #1;
    bus.iRegAddr = 5'h07;
    bus.iTrig    = 1'b1;
    @(posedge iClk); #1;
    bus.iTrig = 1'b0;
    bus.iAddr = 4'd3;
    waitDone();
    check(lastRises == 72, "busy_rises", 64'(lastRises), 64'd72);
    check(dut.sclkOe == 1'b0 && dut.sdioOe == 1'b0 && oCS == 1'b1, "released_bus",
          {61'd0, dut.sclkOe, dut.sdioOe, oCS}, 64'd1);

    // Trigger while another chip is selected: ignored entirely
    bus.iRegAddr = 5'h07;
    bus.iTrig    = 1'b1;
    @(posedge iClk); #1;
    bus.iTrig = 1'b0;
    repeat (200) @(posedge iClk);
    #1;
    check(oCS == 1'b1 && riseCnt == 0 && bus.oReady == 1'b1, "foreign_trig",
          {61'd0, oCS, riseCnt != 0, bus.oReady}, 64'd5);
    bus.iAddr = 4'd0;
    @(posedge iClk); #1;

    // Randomised reads over the whole address space
    for (int i = 0; i < 16; i++) begin
      readFull(5'($urandom_range(0, 31)), {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
